// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg: shared state encoding and counter widths for the filter step sequencer.
package filter_seq_pkg;
    typedef enum logic [2:0] {IDLE, FRST, DRIVE, NEXT, FIN} seq_state_t;
    localparam int FRST_CYCLES = 2;
    localparam int HCNT_W      = 16;
    localparam int SETTLE_W    = 16;
endpackage

// File: rtl/fixed_abs_err.sv
// fixed_abs_err: |a-b| on a one-bit-wider path so extreme codes never wrap, plus out-of-tolerance flag.
module fixed_abs_err #(
    parameter int               WIDTH = 25,
    parameter logic [WIDTH-1:0] TOL   = '0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic        [WIDTH:0]   abs_err,
    output logic                    out_tol
);
    logic signed [WIDTH:0] diff;
    assign diff    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign abs_err = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign out_tol = abs_err > {1'b0, TOL};
endmodule

// File: rtl/filter_step_sequencer.sv
// filter_step_sequencer: resets the filter, applies alternating HI/LO steps and
// measures worst-case settling time and final-cycle tolerance for a pass/fail verdict.
module filter_step_sequencer
    import filter_seq_pkg::*;
#(
    parameter int                      WIDTH       = 25,
    parameter logic signed [WIDTH-1:0] STEP_HI     = 25'sd1000000,
    parameter logic signed [WIDTH-1:0] STEP_LO     = -25'sd1000000,
    parameter int                      HOLD_CYCLES = 1024,
    parameter logic [WIDTH-1:0]        SETTLE_TOL  = 25'd1000,
    parameter int                      NUM_STEPS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] v_out,
    output logic signed [WIDTH-1:0] v_in,
    output logic                    filter_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [SETTLE_W-1:0]     max_settle,
    output logic [7:0]              step_idx
);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [HCNT_W-1:0] FRST_LAST = HCNT_W'(FRST_CYCLES - 1);
    localparam logic [7:0]        STEP_LAST = 8'(NUM_STEPS - 1);

    seq_state_t              state_q, state_d;
    logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
    logic [SETTLE_W-1:0]     last_bad_q, last_bad_d, max_q, max_d;
    logic [7:0]              step_q, step_d;
    logic signed [WIDTH-1:0] v_in_q, v_in_d, target;
    logic                    frst_q, frst_d, busy_q, busy_d, done_q, done_d;
    logic                    pass_q, pass_d, fail_q, fail_d;
    logic [WIDTH:0]          abs_err;
    logic                    out_tol, bad;
    logic [HCNT_W:0]         hcnt_inc;
    logic [SETTLE_W-1:0]     bad_cnt, settle;

    assign target = step_q[0] ? STEP_LO : STEP_HI;

    fixed_abs_err #(.WIDTH(WIDTH), .TOL(SETTLE_TOL)) u_err (
        .a(v_out), .b(target), .abs_err(abs_err), .out_tol(out_tol)
    );

    assign bad      = out_tol && abs_err != '0;
    assign hcnt_inc = {1'b0, hcnt_q} + (HCNT_W + 1)'(1);
    // settle time is "last bad cycle + 1", saturated at the counter width
    assign bad_cnt  = hcnt_inc[HCNT_W] ? '1 : hcnt_inc[SETTLE_W-1:0];
    assign settle   = bad ? bad_cnt : last_bad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            last_bad_q <= '0;
            max_q      <= '0;
            step_q     <= '0;
            v_in_q     <= '0;
            frst_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            last_bad_q <= last_bad_d;
            max_q      <= max_d;
            step_q     <= step_d;
            v_in_q     <= v_in_d;
            frst_q     <= frst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        last_bad_d = last_bad_q;
        max_d      = max_q;
        step_d     = step_q;
        v_in_d     = v_in_q;
        frst_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FRST;
                frst_d  = 1'b1;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
                max_d   = '0;
                fail_d  = 1'b0;
                step_d  = '0;
                hcnt_d  = '0;
                v_in_d  = '0;
            end
            FRST: begin
                frst_d = 1'b1;
                hcnt_d = hcnt_q + HCNT_W'(1);
                if (hcnt_q == FRST_LAST) begin
                    state_d    = DRIVE;
                    frst_d     = 1'b0;
                    hcnt_d     = '0;
                    last_bad_d = '0;
                    v_in_d     = STEP_HI;
                end
            end
            DRIVE: begin
                hcnt_d = hcnt_q + HCNT_W'(1);
                if (bad) last_bad_d = bad_cnt;
                if (hcnt_q == HOLD_LAST) begin
                    max_d      = settle > max_q ? settle : max_q;
                    fail_d     = fail_q | bad;
                    hcnt_d     = '0;
                    last_bad_d = '0;
                    if (step_q == STEP_LAST) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        pass_d  = !(fail_q | bad);
                    end else begin
                        state_d = NEXT;
                        step_d  = step_q + 8'd1;
                        v_in_d  = step_q[0] ? STEP_HI : STEP_LO;
                    end
                end
            end
            NEXT: state_d = DRIVE;
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                v_in_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign v_in       = v_in_q;
    assign filter_rst = frst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign max_settle = max_q;
    assign step_idx   = step_q;
endmodule

// File: tb/tb_filter_step_sequencer.sv
// tb_filter_step_sequencer: timeline model of a run checked every cycle, plus
// hand-computed latency/settle/pass expectations for several filter behaviours.
module tb_filter_step_sequencer;
    localparam int W = 16, H = 20, N = 2, TOL = 10, HI = 1000, LO = -1000;
    localparam logic signed [W-1:0] VMIN = 16'sh8000;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic signed [W-1:0] v_out = '0;
    logic signed [W-1:0] v_in;
    logic filter_rst, busy, done, pass;
    logic [15:0] max_settle;
    logic [7:0] step_idx;
    int checks = 0, errors = 0;

    filter_step_sequencer #(
        .WIDTH(W), .STEP_HI(16'sd1000), .STEP_LO(-16'sd1000),
        .HOLD_CYCLES(H), .SETTLE_TOL(16'd10), .NUM_STEPS(N)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .v_out(v_out), .v_in(v_in),
        .filter_rst(filter_rst), .busy(busy), .done(done), .pass(pass),
        .max_settle(max_settle), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    // filter stand-in: registered; passes v_in once it has been stable for lag samples, else 0
    int mode = 0, lag = 1, run_len = 0;
    logic signed [W-1:0] last_in = '0;
    always @(posedge clk) begin
        run_len <= (v_in == last_in) ? run_len + 1 : 1;
        last_in <= v_in;
        v_out   <= mode == 1 ? '0 : mode == 2 ? VMIN :
                   (((v_in == last_in) ? run_len + 1 : 1) >= lag ? v_in : '0);
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic int tgt(input int s);
        return (s % 2 == 0) ? HI : LO;
    endfunction

    function automatic int iabs(input int x);
        return x < 0 ? -x : x;
    endfunction

    bit act = 0, fr_hold = 1, e_pass = 0, e_fail = 0;
    int t = 0, e_step = 0, e_max = 0;
    int samp [N][H];

    // phases: 0 idle, 1 filter reset, 2 drive, 3 next, 4 fin
    always @(negedge clk) begin
        int u, s, r, ph, ev, sb;
        if (rst) begin
            act = 0; fr_hold = 1; e_step = 0; e_max = 0; e_pass = 0;
        end
        ph = 0; s = 0; r = 0;
        if (act) begin
            if (t < 2) ph = 1;
            else begin
                u = t - 2; s = u / (H + 1); r = u % (H + 1);
                ph = (u == N * (H + 1) - 1) ? 4 : (r < H ? 2 : 3);
            end
        end
        ev = (ph <= 1) ? 0 : (ph == 3 ? tgt(s + 1) : tgt(s));
        if (ph == 1) e_step = 0;
        else if (ph == 3) e_step = s + 1;
        else if (ph != 0) e_step = s;
        chk("v_in", v_in, ev);
        chk("filter_rst", filter_rst, ph == 1 || (ph == 0 && fr_hold));
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 4);
        chk("pass", pass, e_pass);
        chk("max_settle", max_settle, e_max);
        chk("step_idx", step_idx, e_step);
        if (!rst) begin
            if (ph == 2) begin
                samp[s][r] = v_out;
                if (r == H - 1) begin
                    sb = 0;
                    for (int i = 0; i < H; i++)
                        if (iabs(samp[s][i] - tgt(s)) > TOL) sb = i + 1;
                    if (sb > e_max) e_max = sb;
                    if (iabs(samp[s][H-1] - tgt(s)) > TOL) e_fail = 1;
                    if (s == N - 1) e_pass = !e_fail;
                end
            end
            if (ph == 0) begin
                fr_hold = 0;
                if (start) begin
                    act = 1; t = 0; e_pass = 0; e_max = 0; e_fail = 0;
                end
            end else if (ph == 4) act = 0;
            else t++;
        end
    end

    task automatic run_once(output int n);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 200);
    endtask

    task automatic count_done(input int cyc, output int c);
        c = 0;
        repeat (cyc) begin
            @(posedge clk); #1;
            if (done) c++;
        end
    endtask

    initial begin
        int n, c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_v_in", v_in, 0);
        chk("reset_filter_rst", filter_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_max", max_settle, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("release_filter_rst", filter_rst, 0);

        mode = 0; lag = 1;
        run_once(n);
        chk("ideal_latency", n, 44);
        chk("ideal_pass", pass, 1);
        chk("ideal_max", max_settle, 1);
        repeat (3) @(posedge clk);
        #1;

        lag = 7;
        run_once(n);
        chk("lag7_latency", n, 44);
        chk("lag7_pass", pass, 1);
        chk("lag7_max", max_settle, 7);
        repeat (3) @(posedge clk);
        #1;

        mode = 1;
        run_once(n);
        chk("stuck_pass", pass, 0);
        chk("stuck_max", max_settle, 20);
        count_done(50, c);
        chk("stuck_extra_done", c, 0);

        mode = 2;
        run_once(n);
        chk("negmin_pass", pass, 0);
        chk("negmin_max", max_settle, 20);
        repeat (3) @(posedge clk);
        #1;

        mode = 0; lag = 1;
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
        end while (n < 18);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_filter_rst", filter_rst, 1);
        chk("async_rst_v_in", v_in, 0);
        chk("async_rst_step", step_idx, 0);
        chk("async_rst_pass", pass, 0);
        chk("async_rst_max", max_settle, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_done(60, c);
        chk("rst_no_done", c, 0);
        run_once(n);
        chk("post_rst_latency", n, 44);
        chk("post_rst_pass", pass, 1);
        repeat (3) @(posedge clk);
        #1;

        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 200);
        chk("held_first_latency", n, 44);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("held_idle_gap", busy, 0);
            if (n == 2) chk("held_restart", busy, 1);
        end while (!done && n < 200);
        chk("held_second_latency", n, 45);
        start = 1'b0;
        count_done(60, c);
        chk("held_no_third", c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
